// File: rtl/oets_pkg.sv
// Shared types and the compare-exchange decision for the odd-even transposition sorter.
package oets_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SORT,
      DONE
   } state_t;

   // Keys are zero-extended to this width before comparing, so any WIDTH up to it is supported.
   localparam int KEY_MAX_W = 64;

   function automatic logic cmp_swap(
      input logic [KEY_MAX_W-1:0] a,
      input logic [KEY_MAX_W-1:0] b,
      input logic                 descend
   );
      // Strict compares leave equal keys in place, which is what keeps the sort stable.
      return descend ? (a < b) : (a > b);
   endfunction

endpackage

// File: rtl/oets_cmp_exch.sv
// Combinational compare-exchange cell: orders one key/tag pair and flags whether it swapped.
module oets_cmp_exch
   import oets_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IDX_W = 3
)(
   input  logic [WIDTH-1:0] lo_key,
   input  logic [WIDTH-1:0] hi_key,
   input  logic [IDX_W-1:0] lo_tag,
   input  logic [IDX_W-1:0] hi_tag,
   input  logic             descend,
   output logic [WIDTH-1:0] first_key,
   output logic [WIDTH-1:0] second_key,
   output logic [IDX_W-1:0] first_tag,
   output logic [IDX_W-1:0] second_tag,
   output logic             swapped
);

   assign swapped    = cmp_swap(KEY_MAX_W'(lo_key), KEY_MAX_W'(hi_key), descend);
   assign first_key  = swapped ? hi_key : lo_key;
   assign second_key = swapped ? lo_key : hi_key;
   assign first_tag  = swapped ? hi_tag : lo_tag;
   assign second_tag = swapped ? lo_tag : hi_tag;

endmodule

// File: rtl/oets_sorter.sv
// N-key odd-even transposition sorter with stable arg-sort tags, one phase per clock.
// Define OETS_EARLY_EXIT_EN to finish once two consecutive phases make no swap.
module oets_sorter
   import oets_pkg::*;
#(
   parameter int N     = 6,
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(N)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             descend,
   input  logic [WIDTH-1:0] data_in     [N],
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data_sorted [N],
   output logic [IDX_W-1:0] idx_sorted  [N]
);

   localparam int PH_W     = $clog2(N + 1);
   localparam int NUM_EVEN = N / 2;
   localparam int NUM_ODD  = (N - 1) / 2;
   localparam int ODD_SW   = (NUM_ODD > 0) ? NUM_ODD : 1;

   state_t              state;
   state_t              state_next;
   logic [PH_W-1:0]     phase;
   logic                desc_q;
   logic [WIDTH-1:0]    key      [N];
   logic [IDX_W-1:0]    tag      [N];
   logic [WIDTH-1:0]    even_key [N];
   logic [WIDTH-1:0]    odd_key  [N];
   logic [WIDTH-1:0]    next_key [N];
   logic [IDX_W-1:0]    even_tag [N];
   logic [IDX_W-1:0]    odd_tag  [N];
   logic [IDX_W-1:0]    next_tag [N];
   logic [NUM_EVEN-1:0] even_swap;
   logic [ODD_SW-1:0]   odd_swap;
   logic                accept;
   logic                finish;
   logic                last_phase;
   logic                clean_exit;

   // Even-phase row: pairs (0,1),(2,3)..; a trailing element with odd N passes straight through.
   for (genvar k = 0; k < NUM_EVEN; k++) begin : g_even
      oets_cmp_exch #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_cx (
         .lo_key     (key[2*k]),
         .hi_key     (key[2*k+1]),
         .lo_tag     (tag[2*k]),
         .hi_tag     (tag[2*k+1]),
         .descend    (desc_q),
         .first_key  (even_key[2*k]),
         .second_key (even_key[2*k+1]),
         .first_tag  (even_tag[2*k]),
         .second_tag (even_tag[2*k+1]),
         .swapped    (even_swap[k])
      );
   end
   if (N % 2 == 1) begin : g_even_tail
      assign even_key[N-1] = key[N-1];
      assign even_tag[N-1] = tag[N-1];
   end

   // Odd-phase row: pairs (1,2),(3,4)..; element 0 and, for even N, the last element pass through.
   assign odd_key[0] = key[0];
   assign odd_tag[0] = tag[0];
   for (genvar k = 0; k < NUM_ODD; k++) begin : g_odd
      oets_cmp_exch #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_cx (
         .lo_key     (key[2*k+1]),
         .hi_key     (key[2*k+2]),
         .lo_tag     (tag[2*k+1]),
         .hi_tag     (tag[2*k+2]),
         .descend    (desc_q),
         .first_key  (odd_key[2*k+1]),
         .second_key (odd_key[2*k+2]),
         .first_tag  (odd_tag[2*k+1]),
         .second_tag (odd_tag[2*k+2]),
         .swapped    (odd_swap[k])
      );
   end
   if (N % 2 == 0) begin : g_odd_tail
      assign odd_key[N-1] = key[N-1];
      assign odd_tag[N-1] = tag[N-1];
   end
   if (NUM_ODD == 0) begin : g_no_odd
      assign odd_swap = '0;
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         next_key[i] = phase[0] ? odd_key[i] : even_key[i];
         next_tag[i] = phase[0] ? odd_tag[i] : even_tag[i];
      end
   end

   assign last_phase = (phase == PH_W'(N - 1));

`ifdef OETS_EARLY_EXIT_EN
   logic any_swap;
   logic prev_clean;

   assign any_swap   = phase[0] ? |odd_swap : |even_swap;
   assign clean_exit = prev_clean && !any_swap;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_clean <= 1'b0;
      end else if (accept) begin
         prev_clean <= 1'b0;
      end else if (state == SORT) begin
         prev_clean <= !any_swap;
      end
   end
`else
   // Swap flags are only consumed by the early-exit path; fold them into a sink otherwise.
   logic unused_swap;
   assign unused_swap = ^{even_swap, odd_swap};
   assign clean_exit  = 1'b0;
`endif

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every always_comb output is defaulted first so no path can infer a latch.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      finish     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = SORT;
            end
         end
         SORT: begin
            if (last_phase || clean_exit) begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: the key/tag arrays are reset explicitly because an aborted sort must leave no residue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase  <= '0;
         desc_q <= 1'b0;
         for (int i = 0; i < N; i++) begin
            key[i]         <= '0;
            tag[i]         <= '0;
            data_sorted[i] <= '0;
            idx_sorted[i]  <= '0;
         end
      end else if (accept) begin
         phase  <= '0;
         desc_q <= descend;
         for (int i = 0; i < N; i++) begin
            key[i] <= data_in[i];
            tag[i] <= IDX_W'(i);
         end
      end else if (state == SORT) begin
         phase <= phase + 1'b1;
         for (int i = 0; i < N; i++) begin
            key[i] <= next_key[i];
            tag[i] <= next_tag[i];
            if (finish) begin
               data_sorted[i] <= next_key[i];
               idx_sorted[i]  <= next_tag[i];
            end
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_oets_sorter.sv
// Scoreboard bench for oets_sorter: a stable insertion-sort model predicts each result and a
// negedge monitor checks every done pulse; a second N=7, WIDTH=4 instance covers all-equal keys.
module tb_oets_sorter;

   localparam int N   = 6;
   localparam int W   = 8;
   localparam int IW  = $clog2(N);
   localparam int N7  = 7;
   localparam int W7  = 4;
   localparam int IW7 = $clog2(N7);

   typedef struct packed {
      logic [N-1:0][W-1:0]  keys;
      logic [N-1:0][IW-1:0] idx;
      int                   acc;     // edge number of the accepting edge
      int                   lat_lo;
      int                   lat_hi;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          descend = 1'b0;
   logic [W-1:0]  din  [N];
   logic          busy;
   logic          done;
   logic [W-1:0]  dout [N];
   logic [IW-1:0] iout [N];

   logic           start7 = 1'b0;
   logic           descend7 = 1'b0;
   logic [W7-1:0]  din7  [N7];
   logic           busy7;
   logic           done7;
   logic [W7-1:0]  dout7 [N7];
   logic [IW7-1:0] iout7 [N7];

   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   int   n_done = 0;
   exp_t sb[$];

   oets_sorter #(.N(N), .WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .descend     (descend),
      .data_in     (din),
      .busy        (busy),
      .done        (done),
      .data_sorted (dout),
      .idx_sorted  (iout)
   );

   oets_sorter #(.N(N7), .WIDTH(W7)) dut7 (
      .clk         (clk),
      .rst         (rst),
      .start       (start7),
      .descend     (descend7),
      .data_in     (din7),
      .busy        (busy7),
      .done        (done7),
      .data_sorted (dout7),
      .idx_sorted  (iout7)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic ok, input string detail);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   // Reference: stable insertion sort on (key, original index) pairs.
   function automatic exp_t model(input logic [N-1:0][W-1:0] k, input logic d);
      exp_t e;
      int   ks[N];
      int   ix[N];
      int   t;
      bit   presorted;
      e = '0;
      presorted = 1'b1;
      for (int i = 0; i < N; i++) begin
         ks[i] = int'(k[i]);
         ix[i] = i;
      end
      for (int i = 1; i < N; i++)
         if (d ? (ks[i-1] < ks[i]) : (ks[i-1] > ks[i])) presorted = 1'b0;
      for (int i = 1; i < N; i++) begin
         int j = i;
         while (j > 0 && (d ? (ks[j-1] < ks[j]) : (ks[j-1] > ks[j]))) begin
            t = ks[j]; ks[j] = ks[j-1]; ks[j-1] = t;
            t = ix[j]; ix[j] = ix[j-1]; ix[j-1] = t;
            j--;
         end
      end
      for (int i = 0; i < N; i++) begin
         e.keys[i] = W'(ks[i]);
         e.idx[i]  = IW'(ix[i]);
      end
`ifdef OETS_EARLY_EXIT_EN
      e.lat_lo = presorted ? 3 : 4;
      e.lat_hi = presorted ? 3 : N + 1;
`else
      e.lat_lo = N + 1;
      e.lat_hi = N + 1;
`endif
      return e;
   endfunction

   function automatic logic [N-1:0][W-1:0] mk(input int a0, a1, a2, a3, a4, a5);
      logic [N-1:0][W-1:0] k;
      k[0] = W'(a0); k[1] = W'(a1); k[2] = W'(a2);
      k[3] = W'(a3); k[4] = W'(a4); k[5] = W'(a5);
      return k;
   endfunction

   // Bounded wait for the sorter to return to idle; called and returns on a negedge.
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", !busy, $sformatf("busy=%0b after %0d cycles, want 0", busy, n));
   endtask

   task automatic run_sort(input logic [N-1:0][W-1:0] k, input logic d, input bit expect_it);
      exp_t e;
      wait_idle();
      e = model(k, d);
      e.acc = cyc + 1;
      for (int i = 0; i < N; i++) din[i] = k[i];
      descend = d;
      start = 1'b1;
      if (expect_it) sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < N; i++) din[i] = W'($urandom);
      descend = 1'($urandom);
   endtask

   task automatic run7(input logic d);
      int acc;
      int lat;
      bit seen;
      bit ok_d;
      bit ok_i;
      int exp_lat;
`ifdef OETS_EARLY_EXIT_EN
      exp_lat = 3;
`else
      exp_lat = N7 + 1;
`endif
      seen = 1'b0;
      acc = cyc + 1;
      for (int i = 0; i < N7; i++) din7[i] = 4'hF;
      descend7 = d;
      start7 = 1'b1;
      @(negedge clk);
      start7 = 1'b0;
      for (int t = 0; t < 30 && !seen; t++) begin
         if (done7) seen = 1'b1;
         else @(negedge clk);
      end
      if (done7) seen = 1'b1;
      check("n7_done_seen", seen, $sformatf("done7=%0b, want 1 within bound", done7));
      if (seen) begin
         lat = cyc - acc + 1;
         ok_d = 1'b1;
         ok_i = 1'b1;
         for (int i = 0; i < N7; i++) begin
            if (dout7[i] != 4'hF) ok_d = 1'b0;
            if (iout7[i] != IW7'(i)) ok_i = 1'b0;
         end
         check("n7_data", ok_d, $sformatf("got %h %h %h %h %h %h %h, want all f",
               dout7[0], dout7[1], dout7[2], dout7[3], dout7[4], dout7[5], dout7[6]));
         check("n7_idx", ok_i, $sformatf("got %0d %0d %0d %0d %0d %0d %0d, want 0..6",
               iout7[0], iout7[1], iout7[2], iout7[3], iout7[4], iout7[5], iout7[6]));
         check("n7_latency", lat == exp_lat, $sformatf("got %0d, want %0d", lat, exp_lat));
         @(negedge clk);
      end
   endtask

   // Monitor: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (done) begin
         exp_t                 e;
         logic [N-1:0][W-1:0]  gk;
         logic [N-1:0][IW-1:0] gi;
         int                   lat;
         n_done++;
         check("busy_in_done", busy == 1'b1, $sformatf("busy=%0b, want 1", busy));
         check("done_expected", sb.size() != 0,
               $sformatf("queue size %0d, want >0", sb.size()));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            for (int i = 0; i < N; i++) begin
               gk[i] = dout[i];
               gi[i] = iout[i];
            end
            lat = cyc - e.acc + 1;
            check("data", gk == e.keys, $sformatf("got %h, want %h", gk, e.keys));
            check("idx", gi == e.idx, $sformatf("got %h, want %h", gi, e.idx));
            check("latency", lat >= e.lat_lo && lat <= e.lat_hi,
                  $sformatf("got %0d, want %0d..%0d", lat, e.lat_lo, e.lat_hi));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0][W-1:0] k;
      bit                  zero_ok;
      int                  dn0;

      for (int i = 0; i < N; i++) din[i] = '0;
      for (int i = 0; i < N7; i++) din7[i] = '0;

      // Reset state.
      #2 rst = 1'b0;
      #1;
      zero_ok = 1'b1;
      for (int i = 0; i < N; i++) if (dout[i] != '0 || iout[i] != '0) zero_ok = 1'b0;
      check("reset_flags", !busy && !done && !busy7 && !done7,
            $sformatf("busy=%0b done=%0b busy7=%0b done7=%0b, want 0", busy, done, busy7, done7));
      check("reset_outputs", zero_ok, "data_sorted/idx_sorted nonzero, want all 0");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Directed cases.
      run_sort(mk(5, 0, 2, 1, 1, 3), 1'b0, 1'b1);
      run_sort(mk(3, 2, 4, 0, 1, 5), 1'b1, 1'b1);
      run_sort(mk(1, 1, 1, 0, 2, 0), 1'b0, 1'b1);
      run_sort(mk(0, 1, 2, 3, 4, 5), 1'b0, 1'b1);
      run_sort(mk(5, 4, 3, 2, 1, 0), 1'b1, 1'b1);
      run_sort(mk(255, 0, 255, 0, 128, 128), 1'b0, 1'b1);

      // Start pulsed again during a sort is ignored.
      wait_idle();
      dn0 = n_done;
      run_sort(mk(5, 4, 3, 2, 1, 0), 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      for (int i = 0; i < N; i++) din[i] = W'(9 - i);
      descend = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      check("restart_ignored", n_done == dn0 + 1 && !busy,
            $sformatf("done pulses %0d busy=%0b, want 1 and 0", n_done - dn0, busy));

      // Randomized sorts, alternating narrow (many ties) and full key ranges.
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < N; i++)
            k[i] = (t % 2 == 1) ? W'($urandom_range(0, 3)) : W'($urandom);
         run_sort(k, 1'($urandom), 1'b1);
      end

      // Asynchronous reset mid-sort aborts with no done pulse.
      wait_idle();
      repeat (2) @(negedge clk);
      dn0 = n_done;
      run_sort(mk(9, 8, 7, 6, 5, 4), 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      zero_ok = 1'b1;
      for (int i = 0; i < N; i++) if (dout[i] != '0 || iout[i] != '0) zero_ok = 1'b0;
      check("abort_flags", !busy && !done, $sformatf("busy=%0b done=%0b, want 0", busy, done));
      check("abort_outputs", zero_ok, "outputs nonzero during reset, want all 0");
      @(negedge clk);
      rst = 1'b1;
      repeat (N + 4) @(negedge clk);
      check("abort_no_done", n_done == dn0 && !busy,
            $sformatf("done pulses %0d busy=%0b, want 0 and 0", n_done - dn0, busy));
      run_sort(mk(7, 3, 7, 1, 0, 3), 1'b1, 1'b1);
      run_sort(mk(7, 3, 7, 1, 0, 3), 1'b0, 1'b1);

      // N=7, WIDTH=4, all keys equal.
      run7(1'b0);
      run7(1'b1);

      wait_idle();
      repeat (2) @(negedge clk);
      check("scoreboard_drained", sb.size() == 0,
            $sformatf("%0d results still pending, want 0", sb.size()));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
